// File: rtl/hazard_scheduler.sv
// Hazard scheduler for the 5-stage MIPS pipeline: stall/flush control, forwarding selects,
// multi-cycle data-memory wait sequencing with a timeout watchdog, and perf counters.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             DMemReadyM,
  input  logic             ClrCounters,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} stateT;

  stateT           state;
  logic [WC_W-1:0] waitCnt;
  logic            lwStall;
  logic            branchStall;
  logic            memAccess;
  logic            freeze;
  logic            hazard;

  // Register 0 is hard-wired to zero, so it never forms a dependency.
  function automatic logic match(input logic [4:0] x, input logic [4:0] y, input logic we);
    return (x != 5'd0) && (x == y) && we;
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic [4:0] wrM,
                                        input logic weM, input logic [4:0] wrW,
                                        input logic weW);
    if (match(src, wrM, weM))      return 2'b10;
    else if (match(src, wrW, weW)) return 2'b01;
    else                           return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwdSel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    ForwardBE = fwdSel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    ForwardAD = match(RsD, WriteRegM, RegWriteM);
    ForwardBD = match(RtD, WriteRegM, RegWriteM);
  end

  always_comb begin
    lwStall     = MemtoRegE &&
                  (match(RsD, WriteRegE, RegWriteE) || match(RtD, WriteRegE, RegWriteE));
    branchStall = BranchD &&
                  (match(RsD, WriteRegE, RegWriteE) || match(RtD, WriteRegE, RegWriteE) ||
                   (MemtoRegM && (match(RsD, WriteRegM, RegWriteM) ||
                                  match(RtD, WriteRegM, RegWriteM))));
    memAccess   = MemtoRegM || MemWriteM;
    hazard      = lwStall || branchStall;
    // The first not-ready cycle freezes from the inputs, before the state has moved.
    freeze      = (state != RUN) || (memAccess && !DMemReadyM);
  end

  // A freeze holds E rather than bubbling it, so it masks the load-use/branch flush.
  always_comb begin
    StallF = freeze || hazard;
    StallD = freeze || hazard;
    StallE = freeze;
    StallM = freeze;
    FlushW = freeze;
    FlushE = !freeze && hazard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      waitCnt       <= '0;
      MemTimeoutErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memAccess && !DMemReadyM) begin
            state   <= MEM_WAIT;
            waitCnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (DMemReadyM) begin
            state <= RUN;
          end else if (waitCnt == TIMEOUT_V) begin
            state         <= HALT;
            MemTimeoutErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else if (ClrCounters) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != '1)) StallCycles <= StallCycles + CNT_W'(1);
      if (FlushE && (FlushCount != '1))  FlushCount  <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios plus randomized traffic against a
// behavioural model of the scheduling rules.
module tb_hazard_scheduler;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 6;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clk, rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic BranchD, DMemReadyM, ClrCounters;
  logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic MemTimeoutErr;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  hazard_scheduler #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .DMemReadyM(DMemReadyM), .ClrCounters(ClrCounters),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeoutErr(MemTimeoutErr),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a memory wait is "waiting" with a count of not-ready cycles seen.
  bit mWaiting, mHalted, mErr;
  int mWaitN, mStall, mFlush;
  bit eStallF, eFlushE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return (src != 0) && (src == dst) && (we == 1'b1);
  endfunction

  function automatic int fwd(input logic [4:0] src);
    if (dep(src, WriteRegM, RegWriteM)) return 2;
    if (dep(src, WriteRegW, RegWriteW)) return 1;
    return 0;
  endfunction

  task automatic resetModel();
    mWaiting = 0; mHalted = 0; mErr = 0; mWaitN = 0; mStall = 0; mFlush = 0;
  endtask

  task automatic clearIns();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    MemWriteM = 0; BranchD = 0; DMemReadyM = 1; ClrCounters = 0;
  endtask

  task automatic checkAll(input string tag);
    bit useE, loadM, frz, haz;
    useE  = dep(RsD, WriteRegE, RegWriteE) || dep(RtD, WriteRegE, RegWriteE);
    loadM = MemtoRegM && (dep(RsD, WriteRegM, RegWriteM) || dep(RtD, WriteRegM, RegWriteM));
    haz   = (MemtoRegE && useE) || (BranchD && (useE || loadM));
    frz   = mHalted || mWaiting || ((MemtoRegM || MemWriteM) && !DMemReadyM);
    eStallF = frz || haz;
    eFlushE = !frz && haz;
    chk({tag, ".StallF"}, StallF, eStallF);
    chk({tag, ".StallD"}, StallD, eStallF);
    chk({tag, ".StallE"}, StallE, frz);
    chk({tag, ".StallM"}, StallM, frz);
    chk({tag, ".FlushE"}, FlushE, eFlushE);
    chk({tag, ".FlushW"}, FlushW, frz);
    chk({tag, ".FwdAE"}, ForwardAE, fwd(RsE));
    chk({tag, ".FwdBE"}, ForwardBE, fwd(RtE));
    chk({tag, ".FwdAD"}, ForwardAD, dep(RsD, WriteRegM, RegWriteM));
    chk({tag, ".FwdBD"}, ForwardBD, dep(RtD, WriteRegM, RegWriteM));
    chk({tag, ".Err"}, MemTimeoutErr, mErr);
    chk({tag, ".StallCnt"}, StallCycles, mStall);
    chk({tag, ".FlushCnt"}, FlushCount, mFlush);
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    checkAll(tag);
    @(posedge clk);
    if (!rst_n) begin
      resetModel();
    end else begin
      if (ClrCounters) begin
        mStall = 0; mFlush = 0;
      end else begin
        if (eStallF && mStall < CMAX) mStall++;
        if (eFlushE && mFlush < CMAX) mFlush++;
      end
      if (mHalted) begin
      end else if (mWaiting) begin
        if (DMemReadyM) mWaiting = 0;
        else if (mWaitN == MEM_TIMEOUT) begin
          mWaiting = 0; mHalted = 1; mErr = 1;
        end else mWaitN++;
      end else if ((MemtoRegM || MemWriteM) && !DMemReadyM) begin
        mWaiting = 1; mWaitN = 1;
      end
    end
    #1;
  endtask

  initial begin
    clearIns();
    resetModel();
    rst_n = 1'b0;
    #12;
    checkAll("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Forwarding priority
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 chk("fwd.prioM", ForwardAE, 2'b10);
    cycle("fwd.prioM");
    RsE = 0;
    #1 chk("fwd.r0", ForwardAE, 2'b00);
    cycle("fwd.r0");
    RsE = 5; RegWriteM = 0;
    #1 chk("fwd.W", ForwardAE, 2'b01);
    cycle("fwd.W");
    clearIns();

    // Load-use
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
    cycle("loaduse");
    clearIns();
    chk("loaduse.stallCnt", StallCycles, 1);
    chk("loaduse.flushCnt", FlushCount, 1);
    cycle("loaduse.after");

    // Branch hazard then M-stage forward to the compare
    BranchD = 1; RtD = 3; RegWriteE = 1; WriteRegE = 3;
    #1 chk("br.flushE", FlushE, 1);
    cycle("br.stall");
    RegWriteE = 0; WriteRegE = 0; WriteRegM = 3; RegWriteM = 1;
    #1 chk("br.fwdBD", ForwardBD, 1);
    chk("br.noStall", StallF, 0);
    cycle("br.fwd");
    clearIns();

    // Memory wait: 3 not-ready cycles then ready -> 4 frozen cycles
    MemtoRegM = 1; DMemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw.flushW", FlushW, 1);
      cycle("mw.wait");
    end
    DMemReadyM = 1;
    #1 chk("mw.lastFreeze", StallE, 1);
    chk("mw.noFlushE", FlushE, 0);
    cycle("mw.ready");
    clearIns();
    #1 chk("mw.release", StallF, 0);
    chk("mw.stallCnt", StallCycles, 6);
    cycle("mw.run");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); BranchD = 1'($urandom);
      MemtoRegM = ($urandom_range(0, 3) == 0); MemWriteM = ($urandom_range(0, 5) == 0);
      DMemReadyM = ($urandom_range(0, 7) != 0);
      ClrCounters = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    clearIns();

    // Start from a clean state for the remaining directed checks
    rst_n = 1'b0; resetModel();
    #2 rst_n = 1'b1;
    cycle("rst2");

    // Clear wins over a simultaneous stall increment
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8; ClrCounters = 1;
    cycle("clr.stall");
    clearIns();
    chk("clr.stallCnt", StallCycles, 0);
    chk("clr.flushCnt", FlushCount, 0);

    // Timeout -> HALT, then counter saturation
    MemtoRegM = 1; DMemReadyM = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle("to.wait");
    chk("to.errLow", MemTimeoutErr, 0);
    cycle("to.expire");
    chk("to.errHigh", MemTimeoutErr, 1);
    for (int i = 0; i < 70; i++) cycle("to.halt");
    chk("sat.stallCnt", StallCycles, CMAX);
    clearIns();
    #1 chk("halt.frozen", StallM, 1);
    cycle("halt.ready");

    // Asynchronous reset in the middle of HALT
    rst_n = 1'b0;
    #1;
    resetModel();
    chk("rst.err", MemTimeoutErr, 0);
    chk("rst.stallCnt", StallCycles, 0);
    chk("rst.stallF", StallF, 0);
    chk("rst.flushW", FlushW, 0);
    cycle("rst.held");
    rst_n = 1'b1;
    cycle("rst.run");
    cycle("rst.run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
